float_to_fixed_pipe: RTL and testbench

//  Pipelined, multi-channel IEEE-754 single to signed fixed-point converter with a valid/ready stream interface.

---
 rtl/float_to_fixed_pipe.sv | 158 +++++++++++++++
 tb/tb_float_to_fixed_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_fixed_pipe.sv
// Three-stage, multi-lane IEEE-754 single to signed fixed-point converter with
// selectable rounding/saturation, NaN/Inf/zero flags and a sticky overflow-beat counter.
module float_to_fixed_pipe #(
  parameter int C_FXP_WIDTH = 16,
  parameter int C_FXP_POINT = 12,
  parameter int C_FLP_WIDTH = 32,
  parameter int C_CHANNELS  = 3,
  parameter int C_ROUND     = 1,
  parameter int C_SATURATE  = 1
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              S_VALID,
  output logic                              S_READY,
  input  logic [C_CHANNELS*C_FLP_WIDTH-1:0] S_DATA,
  output logic                              M_VALID,
  input  logic                              M_READY,
  output logic [C_CHANNELS*C_FXP_WIDTH-1:0] M_DATA,
  output logic [C_CHANNELS-1:0]             M_OUT_RANGE,
  output logic [C_CHANNELS-1:0]             M_ZERO,
  input  logic                              CLR_CNT,
  output logic [15:0]                       OVF_COUNT
);

  localparam int W = C_FXP_WIDTH;
  localparam int N = C_CHANNELS;
  // k = e - 127 + P - 23 = e - (150 - P)
  localparam logic [9:0]   K_OFF   = 10'(150 - C_FXP_POINT);
  localparam logic [W-1:0] FXP_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] FXP_MIN = {1'b1, {(W-1){1'b0}}};

  // Handshake: a beat moves on an edge where valid & ready are both high. The whole
  // pipe advances together when the output register is empty or being drained;
  // otherwise every stage holds, so M_DATA/flags stay stable while stalled.
  logic advance;
  assign advance = ~M_VALID | M_READY;
  assign S_READY = ARESETN & advance;

  logic                  s1_valid;
  logic [N-1:0]          s1_sign, s1_zero, s1_inf, s1_nan;
  logic [23:0]           s1_man [N];
  logic signed [9:0]     s1_k   [N];

  logic                  s2_valid;
  logic [N-1:0]          s2_sign, s2_zero, s2_inf, s2_nan, s2_big;
  logic [W-1:0]          s2_mag [N];

  logic [W-1:0]          s2n_mag [N];
  logic [N-1:0]          s2n_big;
  logic [N*W-1:0]        s3n_data;
  logic [N-1:0]          s3n_range, s3n_zero;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      M_VALID     <= 1'b0;
      M_DATA      <= '0;
      M_OUT_RANGE <= '0;
      M_ZERO      <= '0;
    end else if (advance) begin
      s1_valid <= S_VALID;
      s2_valid <= s1_valid;
      M_VALID  <= s2_valid;
      if (s2_valid) begin
        M_DATA      <= s3n_data;
        M_OUT_RANGE <= s3n_range;
        M_ZERO      <= s3n_zero;
      end
    end
  end

  // Datapath registers need no reset: their contents are qualified by the stage valids.
  always_ff @(posedge ACLK) begin
    if (advance && S_VALID) begin
      for (int i = 0; i < N; i++) begin
        s1_sign[i] <= S_DATA[i*C_FLP_WIDTH + 31];
        s1_zero[i] <= (S_DATA[i*C_FLP_WIDTH + 23 +: 8] == 8'h00);
        s1_inf[i]  <= (S_DATA[i*C_FLP_WIDTH + 23 +: 8] == 8'hFF) &&
                      (S_DATA[i*C_FLP_WIDTH +: 23] == 23'd0);
        s1_nan[i]  <= (S_DATA[i*C_FLP_WIDTH + 23 +: 8] == 8'hFF) &&
                      (S_DATA[i*C_FLP_WIDTH +: 23] != 23'd0);
        s1_man[i]  <= {1'b1, S_DATA[i*C_FLP_WIDTH +: 23]};
        s1_k[i]    <= {2'b00, S_DATA[i*C_FLP_WIDTH + 23 +: 8]} - K_OFF;
      end
    end
    if (advance && s1_valid) begin
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_inf  <= s1_inf;
      s2_nan  <= s1_nan;
      s2_big  <= s2n_big;
      for (int i = 0; i < N; i++) s2_mag[i] <= s2n_mag[i];
    end
  end

  // Shift and round. A left shift beyond 40 always overflows any legal width.
  always_comb begin
    logic [63:0] man64;
    logic [63:0] wide;
    logic [9:0]  sh;
    man64   = '0;
    wide    = '0;
    sh      = '0;
    s2n_big = '0;
    for (int i = 0; i < N; i++) s2n_mag[i] = '0;
    for (int i = 0; i < N; i++) begin
      man64 = {40'd0, s1_man[i]};
      wide  = '0;
      sh    = '0;
      if (!s1_k[i][9]) begin
        if (s1_k[i] > 10'sd40) wide = '1;
        else                   wide = man64 << s1_k[i][5:0];
      end else begin
        sh = -s1_k[i];
        if (sh > 10'd25) wide = '0;
        else wide = (man64 >> sh[4:0]) +
                    ((C_ROUND != 0) ? ((man64 >> (sh[4:0] - 5'd1)) & 64'd1) : 64'd0);
      end
      s2n_big[i] = |wide[63:W];
      s2n_mag[i] = wide[W-1:0];
    end
  end

  // Sign, saturation and special-value resolution; magnitude 2^(W-1) is legal only when negative.
  always_comb begin
    logic ovf;
    ovf       = 1'b0;
    s3n_data  = '0;
    s3n_range = '0;
    s3n_zero  = '0;
    for (int i = 0; i < N; i++) begin
      ovf = s2_inf[i] | s2_big[i] |
            (s2_mag[i][W-1] & ~(s2_sign[i] & (s2_mag[i][W-2:0] == '0)));
      if (s2_zero[i]) begin
        s3n_zero[i] = 1'b1;
      end else if (s2_nan[i]) begin
        s3n_range[i] = 1'b1;
      end else if (ovf) begin
        s3n_range[i] = 1'b1;
        if (C_SATURATE != 0) s3n_data[i*W +: W] = s2_sign[i] ? FXP_MIN : FXP_MAX;
      end else begin
        s3n_data[i*W +: W] = s2_sign[i] ? -s2_mag[i] : s2_mag[i];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      OVF_COUNT <= '0;
    end else if (CLR_CNT) begin
      OVF_COUNT <= '0;
    end else if (M_VALID && M_READY && (|M_OUT_RANGE) && (OVF_COUNT != 16'hFFFF)) begin
      OVF_COUNT <= OVF_COUNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Directed bench for float_to_fixed_pipe: a rounding/saturating instance and a
// truncating/zeroing instance share the same stimulus and handshake.
module tb_float_to_fixed_pipe;

  logic        clk = 1'b0;
  logic        rst_n, s_valid, m_ready, clr_cnt;
  logic [95:0] s_data;

  logic        s_ready_a, m_valid_a, s_ready_b, m_valid_b;
  logic [47:0] m_data_a, m_data_b;
  logic [2:0]  m_range_a, m_zero_a, m_range_b, m_zero_b;
  logic [15:0] ovf_a, ovf_b;

  int compared   = 0;
  int mismatched = 0;
  int exp_cnt_a  = 0;
  int exp_cnt_b  = 0;
  logic [47:0] exp_q[$];

  logic [31:0] ft [8] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000,
                          32'h3E800000, 32'hBF000000, 32'h40400000, 32'hC0000000};
  logic [15:0] xt [8] = '{16'h1000, 16'h2000, 16'h0800, 16'hF000,
                          16'h0400, 16'hF800, 16'h3000, 16'hE000};

  always #5 clk = ~clk;

  float_to_fixed_pipe u_dut_a (
    .ACLK(clk), .ARESETN(rst_n), .S_VALID(s_valid), .S_READY(s_ready_a), .S_DATA(s_data),
    .M_VALID(m_valid_a), .M_READY(m_ready), .M_DATA(m_data_a), .M_OUT_RANGE(m_range_a),
    .M_ZERO(m_zero_a), .CLR_CNT(clr_cnt), .OVF_COUNT(ovf_a)
  );

  float_to_fixed_pipe #(.C_ROUND(0), .C_SATURATE(0)) u_dut_b (
    .ACLK(clk), .ARESETN(rst_n), .S_VALID(s_valid), .S_READY(s_ready_b), .S_DATA(s_data),
    .M_VALID(m_valid_b), .M_READY(m_ready), .M_DATA(m_data_b), .M_OUT_RANGE(m_range_b),
    .M_ZERO(m_zero_b), .CLR_CNT(clr_cnt), .OVF_COUNT(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] beat_in(input int j);
    return {ft[(j+2)%8], ft[(j+1)%8], ft[j%8]};
  endfunction

  function automatic logic [47:0] beat_exp(input int j);
    return {xt[(j+2)%8], xt[(j+1)%8], xt[j%8]};
  endfunction

  // Drive one beat with M_READY high, capture the output beat and its latency, then drain it.
  task automatic run_beat(input logic [95:0] din,
                          output logic [47:0] da, output logic [2:0] ra, output logic [2:0] za,
                          output logic [47:0] db, output logic [2:0] rb, output logic [2:0] zb,
                          output int lat);
    s_valid = 1'b1;
    s_data  = din;
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid_a && lat < 10) begin
      tick();
      lat++;
    end
    da = m_data_a; ra = m_range_a; za = m_zero_a;
    db = m_data_b; rb = m_range_b; zb = m_zero_b;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; clr_cnt = 1'b0; s_data = '0;
    repeat (3) tick();
    compared++; if (m_valid_a !== 1'b0) begin mismatched++; $display("FAIL reset_m_valid: got %b expected 0", m_valid_a); end
    compared++; if (m_data_a !== 48'h0) begin mismatched++; $display("FAIL reset_m_data: got %h expected 0", m_data_a); end
    compared++; if ({m_range_a, m_zero_a} !== 6'b0) begin mismatched++; $display("FAIL reset_flags: got %b expected 0", {m_range_a, m_zero_a}); end
    compared++; if (ovf_a !== 16'h0) begin mismatched++; $display("FAIL reset_ovf_count: got %h expected 0", ovf_a); end
    compared++; if (s_ready_a !== 1'b0) begin mismatched++; $display("FAIL reset_s_ready: got %b expected 0", s_ready_a); end
    rst_n = 1'b1;
    tick();
    compared++; if (s_ready_a !== 1'b1) begin mismatched++; $display("FAIL post_reset_s_ready: got %b expected 1", s_ready_a); end
  endtask

  task automatic test_basic();
    logic [47:0] da, db;
    logic [2:0]  ra, za, rb, zb;
    int lat;
    run_beat({32'h00000000, 32'hBFC00000, 32'h3F800000}, da, ra, za, db, rb, zb, lat);
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    compared++; if (da !== 48'h0000_E800_1000) begin mismatched++; $display("FAIL basic_data_a: got %h expected 0000e8001000", da); end
    compared++; if (za !== 3'b100) begin mismatched++; $display("FAIL basic_zero_a: got %b expected 100", za); end
    compared++; if (ra !== 3'b000) begin mismatched++; $display("FAIL basic_range_a: got %b expected 000", ra); end
    compared++; if (db !== 48'h0000_E800_1000) begin mismatched++; $display("FAIL basic_data_b: got %h expected 0000e8001000", db); end
    compared++; if (zb !== 3'b100) begin mismatched++; $display("FAIL basic_zero_b: got %b expected 100", zb); end
  endtask

  task automatic test_specials();
    logic [95:0] vin [5];
    logic [47:0] ea_d [5], eb_d [5];
    logic [2:0]  ea_r [5], eb_r [5], ea_z [5], eb_z [5];
    logic [47:0] da, db;
    logic [2:0]  ra, za, rb, zb;
    int lat;
    // range, rounding, rounding-carry boundary, denormal/huge/tiny, k>=0 path
    vin  = '{{32'h7FC00000, 32'hC1000000, 32'h41000000}, {32'hFF800000, 32'hB9000000, 32'h39000000},
             {32'hC0FFFF00, 32'h40FFFF00, 32'h40FFFE00}, {32'h00800000, 32'h7F000000, 32'h00400000},
             {32'h00800000, 32'hC5000000, 32'h45000000}};
    ea_d = '{48'h0000_8000_7FFF, 48'h8000_FFFF_0001, 48'h8000_7FFF_7FFF, 48'h0000_7FFF_0000, 48'h0000_8000_7FFF};
    ea_r = '{3'b101, 3'b100, 3'b010, 3'b010, 3'b011};
    ea_z = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    eb_d = '{48'h0000_8000_0000, 48'h0, 48'h8001_7FFF_7FFF, 48'h0, 48'h0};
    eb_r = '{3'b101, 3'b100, 3'b000, 3'b010, 3'b011};
    eb_z = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    for (int v = 0; v < 5; v++) begin
      run_beat(vin[v], da, ra, za, db, rb, zb, lat);
      if (ea_r[v] != 3'b000) exp_cnt_a++;
      if (eb_r[v] != 3'b000) exp_cnt_b++;
      compared++; if (da !== ea_d[v]) begin mismatched++; $display("FAIL spec_v%0d_data_a: got %h expected %h", v, da, ea_d[v]); end
      compared++; if (ra !== ea_r[v]) begin mismatched++; $display("FAIL spec_v%0d_range_a: got %b expected %b", v, ra, ea_r[v]); end
      compared++; if (za !== ea_z[v]) begin mismatched++; $display("FAIL spec_v%0d_zero_a: got %b expected %b", v, za, ea_z[v]); end
      compared++; if (db !== eb_d[v]) begin mismatched++; $display("FAIL spec_v%0d_data_b: got %h expected %h", v, db, eb_d[v]); end
      compared++; if (rb !== eb_r[v]) begin mismatched++; $display("FAIL spec_v%0d_range_b: got %b expected %b", v, rb, eb_r[v]); end
      compared++; if (zb !== eb_z[v]) begin mismatched++; $display("FAIL spec_v%0d_zero_b: got %b expected %b", v, zb, eb_z[v]); end
    end
    compared++; if (ovf_a !== 16'(exp_cnt_a)) begin mismatched++; $display("FAIL spec_ovf_count_a: got %0d expected %0d", ovf_a, exp_cnt_a); end
    compared++; if (ovf_b !== 16'(exp_cnt_b)) begin mismatched++; $display("FAIL spec_ovf_count_b: got %0d expected %0d", ovf_b, exp_cnt_b); end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s_valid = (c < 4);
      s_data  = beat_in(c);
      #1;
      if (c < 4) begin
        compared++; if (s_ready_a !== 1'b1) begin mismatched++; $display("FAIL b2b_s_ready c%0d: got %b expected 1", c, s_ready_a); end
      end
      tick();
      compared++;
      if (m_valid_a !== (c >= 2 && c <= 5)) begin
        mismatched++; $display("FAIL b2b_m_valid c%0d: got %b expected %b", c, m_valid_a, (c >= 2 && c <= 5));
      end
      if (c >= 2 && c <= 5) begin
        compared++; if (m_data_a !== beat_exp(c-2)) begin mismatched++; $display("FAIL b2b_data c%0d: got %h expected %h", c, m_data_a, beat_exp(c-2)); end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_stream();
    bit rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int idx = 0, got = 0, cyc = 0;
    logic acc, emit, stall_now;
    logic [47:0] held, exp;
    exp_q.delete();
    while (got < 8 && cyc < 200) begin
      m_ready = rpat[cyc % 4];
      s_valid = (idx < 8);
      s_data  = beat_in(idx);
      #1;
      acc  = s_valid & s_ready_a;
      emit = m_valid_a & m_ready;
      if (acc) exp_q.push_back(beat_exp(idx));
      if (emit) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++; $display("FAIL stream_extra_beat: got %h expected no beat", m_data_a);
        end else begin
          exp = exp_q.pop_front();
          if (m_data_a !== exp) begin mismatched++; $display("FAIL stream_data beat%0d: got %h expected %h", got, m_data_a, exp); end
        end
      end
      stall_now = m_valid_a & ~m_ready;
      held = m_data_a;
      tick();
      if (acc) idx++;
      if (emit) got++;
      if (stall_now) begin
        compared++;
        if (m_valid_a !== 1'b1 || m_data_a !== held) begin
          mismatched++; $display("FAIL stream_hold cyc%0d: got %b/%h expected 1/%h", cyc, m_valid_a, m_data_a, held);
        end
      end
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    compared++; if (got !== 8) begin mismatched++; $display("FAIL stream_count: got %0d expected 8", got); end
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL stream_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_counter();
    logic [47:0] da, db;
    logic [2:0]  ra, za, rb, zb;
    int lat, n;
    s_data  = {3{32'h41000000}};
    m_ready = 1'b1;
    s_valid = 1'b1;
    repeat (70000) tick();
    s_valid = 1'b0;
    repeat (5) tick();
    compared++; if (ovf_a !== 16'hFFFF) begin mismatched++; $display("FAIL cnt_saturate_a: got %h expected ffff", ovf_a); end
    compared++; if (ovf_b !== 16'hFFFF) begin mismatched++; $display("FAIL cnt_saturate_b: got %h expected ffff", ovf_b); end
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n = 0;
    while (!m_valid_a && n < 10) begin tick(); n++; end
    compared++; if (m_valid_a !== 1'b1) begin mismatched++; $display("FAIL cnt_clr_wait: got %b expected 1", m_valid_a); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    compared++; if (ovf_a !== 16'h0) begin mismatched++; $display("FAIL cnt_clear_a: got %h expected 0", ovf_a); end
    compared++; if (ovf_b !== 16'h0) begin mismatched++; $display("FAIL cnt_clear_b: got %h expected 0", ovf_b); end
    run_beat({3{32'h41000000}}, da, ra, za, db, rb, zb, lat);
    compared++; if (ovf_a !== 16'h1) begin mismatched++; $display("FAIL cnt_after_clear: got %h expected 1", ovf_a); end
  endtask

  task automatic test_reset_flight();
    int stale = 0;
    s_data  = {3{32'h41000000}};
    m_ready = 1'b1;
    s_valid = 1'b1;
    repeat (3) tick();
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    compared++; if (s_ready_a !== 1'b0) begin mismatched++; $display("FAIL flight_s_ready: got %b expected 0", s_ready_a); end
    tick();
    rst_n = 1'b1;
    compared++; if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0) begin mismatched++; $display("FAIL flight_m_valid: got %b%b expected 00", m_valid_a, m_valid_b); end
    compared++; if (ovf_a !== 16'h0) begin mismatched++; $display("FAIL flight_ovf_count: got %h expected 0", ovf_a); end
    compared++; if (m_data_a !== 48'h0) begin mismatched++; $display("FAIL flight_m_data: got %h expected 0", m_data_a); end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (m_valid_a || m_valid_b) stale++;
    end
    compared++; if (stale !== 0) begin mismatched++; $display("FAIL flight_stale_beats: got %0d expected 0", stale); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_back_to_back();
    test_stream();
    test_counter();
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
